// File: rtl/bf_io_pkg.sv
// Shared types and defaults for the brainfuck core I/O controller.
package bf_io_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_PULSE,
    R_RECOVER
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SETUP,
    W_STROBE,
    W_HOLD
  } wr_state_t;

  localparam int unsigned DEF_DEPTH     = 4;
  localparam int unsigned DEF_PULSE_LEN = 2;
  localparam int unsigned DEF_SETUP     = 1;

endpackage

// File: rtl/bf_io_fifo.sv
// Synchronous byte FIFO with wrapping pointers and an occupancy count.
module bf_io_fifo
  import bf_io_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push_i,
  input  byte_t data_i,
  input  logic  pop_i,
  output logic  full_o,
  output logic  empty_o,
  output byte_t head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  byte_t         mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];

  // Full blocks a push even when a pop frees a slot this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bf_io_ctrl.sv
// Core-side I/O controller: strobed input reads, FIFO-buffered
// output writes with setup / strobe / hold phases.
module bf_io_ctrl
  import bf_io_pkg::*;
#(
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned PULSE_LEN = DEF_PULSE_LEN,
  parameter int unsigned SETUP     = DEF_SETUP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_req,
  output logic       rd_ack,
  output logic [7:0] rd_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  input  logic [7:0] in_byte,
  output logic       in_setready,
  output logic [7:0] out_byte,
  output logic       out_ready,
  output logic       busy
);

  localparam int unsigned CMAX =
    (PULSE_LEN > SETUP) ? PULSE_LEN : SETUP;
  localparam int unsigned CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] PL_LAST = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] SU_LAST = CW'(SETUP - 1);

  rd_state_t     rd_state_q, rd_state_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic          rd_ack_q, rd_ack_d;
  byte_t         rd_data_q, rd_data_d;

  wr_state_t     wr_state_q, wr_state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  byte_t         out_byte_q, out_byte_d;
  logic          busy_q, busy_d;

  logic  fifo_full, fifo_empty, fifo_push, fifo_pop;
  byte_t fifo_head;

  assign wr_ready  = !fifo_full && !rst;
  assign fifo_push = wr_valid && wr_ready;
  assign fifo_pop  = (wr_state_q == W_HOLD);

  bf_io_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (fifo_push),
    .data_i (wr_data),
    .pop_i  (fifo_pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (fifo_head)
  );

  // Byte is captured before the advance strobe moves the device head.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_ack_d   = 1'b0;
    rd_data_d  = rd_data_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (rd_req) begin
          rd_data_d  = in_byte;
          rd_ack_d   = 1'b1;
          rd_cnt_d   = '0;
          rd_state_d = R_PULSE;
        end
      end
      R_PULSE: begin
        if (rd_cnt_q == PL_LAST) rd_state_d = R_RECOVER;
        else                     rd_cnt_d   = rd_cnt_q + 1'b1;
      end
      R_RECOVER: rd_state_d = R_IDLE;
      default:   rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    out_byte_d = out_byte_q;
    unique case (wr_state_q)
      W_IDLE: begin
        if (!fifo_empty) begin
          out_byte_d = fifo_head;
          wr_cnt_d   = '0;
          wr_state_d = W_SETUP;
        end
      end
      W_SETUP: begin
        if (wr_cnt_q == SU_LAST) begin
          wr_cnt_d   = '0;
          wr_state_d = W_STROBE;
        end else begin
          wr_cnt_d = wr_cnt_q + 1'b1;
        end
      end
      W_STROBE: begin
        if (wr_cnt_q == PL_LAST) wr_state_d = W_HOLD;
        else                     wr_cnt_d   = wr_cnt_q + 1'b1;
      end
      W_HOLD:  wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  assign busy_d = !fifo_empty
               || (rd_state_q != R_IDLE)
               || (wr_state_q != W_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      rd_cnt_q   <= '0;
      rd_ack_q   <= 1'b0;
      rd_data_q  <= '0;
      wr_state_q <= W_IDLE;
      wr_cnt_q   <= '0;
      out_byte_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_ack_q   <= rd_ack_d;
      rd_data_q  <= rd_data_d;
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      out_byte_q <= out_byte_d;
      busy_q     <= busy_d;
    end
  end

  assign rd_ack      = rd_ack_q;
  assign rd_data     = rd_data_q;
  assign in_setready = (rd_state_q == R_PULSE);
  assign out_byte    = out_byte_q;
  assign out_ready   = (wr_state_q == W_STROBE);
  assign busy        = busy_q;

endmodule

// File: tb/tb_bf_io_ctrl.sv
// Scoreboard bench for bf_io_ctrl with behavioural device models.
module tb_bf_io_ctrl;
  import bf_io_pkg::*;

  localparam int P = 2;
  localparam int S = 1;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd_req = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] in_byte;
  logic       rd_ack, wr_ready, in_setready, out_ready, busy;
  logic [7:0] rd_data, out_byte;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bf_io_ctrl #(
    .DEPTH(D), .PULSE_LEN(P), .SETUP(S)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .in_byte(in_byte), .in_setready(in_setready),
    .out_byte(out_byte), .out_ready(out_ready), .busy(busy)
  );

  // Input device: byte stream advanced on each setready rising edge.
  logic [7:0] stream [128];
  int in_idx = 0;
  assign in_byte = stream[in_idx[6:0]];
  always @(posedge in_setready) in_idx <= in_idx + 1;

  typedef struct {
    logic [7:0] b;
    int         c;
  } exp_t;

  exp_t rd_exp[$];
  exp_t wr_exp[$];
  logic [7:0] wq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int rd_free = 0;
  int n_reads = 0;
  int wr_L = -1000;
  int first_push = -1;
  int n_rise = 0;
  bit or_abort = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic bad(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  // Read completes one cycle after acceptance; a new acceptance is
  // only possible PULSE_LEN+2 cycles after the previous one.
  task automatic do_read();
    int rc, acc;
    bit got;
    exp_t e;
    @(posedge clk);
    #1;
    rd_req = 1'b1;
    rc  = cyc;
    acc = (rc > rd_free) ? rc : rd_free;
    e.b = stream[n_reads[6:0]];
    e.c = acc + 1;
    rd_exp.push_back(e);
    n_reads++;
    rd_free = acc + P + 2;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (rd_ack) got = 1'b1;
    end
    rd_req = 1'b0;
    if (!got) bad("read_timeout");
  endtask

  // Each emitted byte starts service once it is queued and the
  // previous byte's SETUP+PULSE_LEN+2 slot is over.
  task automatic send_wq();
    bit ok;
    int L;
    exp_t e;
    @(posedge clk);
    #1;
    while (wq.size() > 0) begin
      wr_valid = 1'b1;
      wr_data  = wq[0];
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
        @(negedge clk);
        if (wr_ready) ok = 1'b1;
        else begin
          @(posedge clk);
          #1;
        end
      end
      if (!ok) begin
        bad("write_timeout");
        if (first_push < 0) first_push = cyc;
        wr_valid = 1'b0;
        wq.delete();
        return;
      end
      if (first_push < 0) first_push = cyc;
      L = (cyc + 1 > wr_L + S + P + 2) ? cyc + 1 : wr_L + S + P + 2;
      wr_L = L;
      e.b = wq[0];
      e.c = L + 1 + S;
      wr_exp.push_back(e);
      void'(wq.pop_front());
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (rd_exp.size() == 0 && wr_exp.size() == 0) break;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
  endtask

  bit prev_sr = 1'b0;
  int sr_len = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_ack) begin
        if (rd_exp.size() == 0) bad("unexpected_rd_ack");
        else begin
          e = rd_exp.pop_front();
          chk("rd_data", rd_data, e.b);
          chk("rd_ack_cycle", cyc, e.c);
        end
      end
      if (in_setready && !prev_sr) begin
        chk("setready_with_ack", rd_ack, 1);
        sr_len = 0;
      end
      if (in_setready) sr_len++;
      if (!in_setready && prev_sr) chk("setready_len", sr_len, P);
      prev_sr = in_setready;
    end
  end

  bit prev_or = 1'b0;
  int or_len = 0;
  logic [7:0] cur_b = 8'h00;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_ready && !prev_or) begin
        n_rise++;
        or_len = 0;
        if (wr_exp.size() == 0) begin
          bad("unexpected_out_ready");
          cur_b = out_byte;
        end else begin
          e = wr_exp.pop_front();
          cur_b = e.b;
          chk("out_byte", out_byte, e.b);
          chk("out_rise_cycle", cyc, e.c);
        end
      end
      if (out_ready) begin
        or_len++;
        chk("out_byte_stable", out_byte, cur_b);
      end
      if (!out_ready && prev_or) begin
        if (!or_abort) begin
          chk("out_ready_len", or_len, P);
          chk("out_byte_hold", out_byte, cur_b);
        end
        or_abort = 1'b0;
      end
      prev_or = out_ready;
    end
  end

  initial begin
    int t, r0, m, nb;
    for (int i = 0; i < 128; i++) stream[i] = 8'($urandom);
    stream[0] = 8'h48;
    stream[1] = 8'h69;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_setready", in_setready, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_out_ready", out_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_ready", wr_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("wr_ready_after_rst", wr_ready, 1);

    do_read();
    do_read();
    drain();
    chk("setready_edges_two_reads", in_idx, 2);

    wq = '{8'h41};
    first_push = -1;
    send_wq();
    t = first_push;
    wait_cyc(t + 2);
    chk("single_out_byte_setup", out_byte, 8'h41);
    chk("single_busy", busy, 1);
    wait_cyc(t + 7);
    chk("single_busy_clear", busy, 0);
    drain();

    wq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    first_push = -1;
    fork
      send_wq();
      begin
        wait (first_push >= 0);
        t = first_push;
        wait_cyc(t + 4);
        chk("burst_full_t4", wr_ready, 0);
        wait_cyc(t + 5);
        chk("burst_full_t5", wr_ready, 0);
        wait_cyc(t + 6);
        chk("burst_free_t6", wr_ready, 1);
      end
    join
    drain();

    wq = '{8'($urandom)};
    first_push = -1;
    fork
      do_read();
      send_wq();
    join
    drain();

    for (int it = 0; it < 30; it++) begin
      m  = $urandom_range(0, 2);
      nb = $urandom_range(1, 5);
      wq.delete();
      for (int k = 0; k < nb; k++) wq.push_back(8'($urandom));
      first_push = -1;
      case (m)
        0: do_read();
        1: send_wq();
        default: fork
          do_read();
          send_wq();
        join
      endcase
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    drain();
    chk("busy_idle_after_random", busy, 0);

    wq = '{8'hA1, 8'hA2, 8'hA3};
    first_push = -1;
    fork
      send_wq();
      begin
        wait (first_push >= 0);
        t = first_push;
        wait_cyc(t + 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        or_abort = 1'b1;
        @(negedge clk);
        chk("pre_rst_strobe", out_ready, 1);
        @(negedge clk);
        chk("rst_mid_out_ready", out_ready, 0);
        chk("rst_mid_out_byte", out_byte, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_wr_ready", wr_ready, 0);
        wr_exp.delete();
        wr_L = -1000;
        r0 = n_rise;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("wr_ready_after_mid_rst", wr_ready, 1);
        repeat (15) @(negedge clk);
        chk("no_strobe_after_rst", n_rise - r0, 0);
        chk("busy_after_rst", busy, 0);
      end
    join

    chk("setready_edges_total", in_idx, n_reads);
    chk("rd_queue_empty", rd_exp.size(), 0);
    chk("wr_queue_empty", wr_exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bf_io_ctrl.md
# bf_io_ctrl

CPU-side I/O controller for the brainfuck core, and the initiator end of the two byte-stream I/O devices. It serves `,` reads by sampling the input device's head byte and then strobing its `setready` advance line. It buffers `.` writes in a small FIFO and replays them to the output device as a data byte plus a level-held `ready` strobe. It sits between the core's execute stage and the input/output bus devices; the read and write paths run independently.

## Interface
- `DEPTH`, 4: write FIFO entries. Must be a power of 2 and ≥2.
- `PULSE_LEN`, 2: cycles a device strobe is held high. Must be ≥1.
- `SETUP`, 1: cycles `out_byte` is stable before `out_ready` rises. Must be ≥1.

- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `rd_req` in 1: core requests one input byte; held until `rd_ack`.
- `rd_ack` out 1: one-cycle pulse; `rd_data` is valid in that cycle.
- `rd_data` out 8: byte returned to the core; holds its value until the next read.
- `wr_valid` in 1: core offers `wr_data`.
- `wr_ready` out 1: FIFO can accept; the push happens when `wr_valid && wr_ready`.
- `wr_data` in 8: byte to emit.
- `in_byte` in 8: head byte from the input device.
- `in_setready` out 1: advance strobe to the input device (rising-edge consumer).
- `out_byte` out 8: data to the output device.
- `out_ready` out 1: write strobe to the output device (rising-edge consumer).
- `busy` out 1: FIFO non-empty, or either FSM not idle.

## Operation
- **Reset values.** `rd_ack`, `rd_data`, `in_setready`, `out_byte`, `out_ready` and `busy` are all 0. `wr_ready` is 0 while `rst` is high. The FIFO is emptied and both FSMs go to idle.
- **Read FSM: R_IDLE → R_PULSE → R_RECOVER → R_IDLE.**
  - In R_IDLE with `rd_req` high: latch `rd_data` from `in_byte` (the byte is sampled before the advance), pulse `rd_ack`, and go to R_PULSE.
  - R_PULSE: `in_setready` is high for PULSE_LEN cycles.
  - R_RECOVER: one cycle with `in_setready` low, which guarantees a fresh rising edge on the next read. Then go to R_IDLE.
  - `rd_req` is only examined in R_IDLE, so a request still held after `rd_ack` is never double-served.
- **Write FIFO.** Synchronous FIFO with a `$clog2(DEPTH)+1`-bit count and wrapping pointers.
  - `wr_ready = !full`.
  - A push while full is impossible, even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves the count unchanged.
- **Write FSM: W_IDLE → W_SETUP → W_STROBE → W_HOLD → W_IDLE.**
  - W_IDLE with count ≠ 0: load `out_byte` from the FIFO head and go to W_SETUP.
  - W_SETUP: lasts SETUP cycles with `out_ready` low.
  - W_STROBE: lasts PULSE_LEN cycles with `out_ready` high.
  - W_HOLD: lasts 1 cycle with `out_ready` low; the head entry is popped at the end of the cycle.
  - W_HOLD always returns to W_IDLE.
  - `out_byte` stays constant from W_SETUP through W_HOLD.
- **Ordering.** The read and write paths may be active in the same cycle. Ordering between `.` and `,` is the core's responsibility; it waits for `busy == 0` when ordering matters.
- **Reset mid-operation.** The strobes drop at the next edge and FIFO contents are discarded. A byte whose `out_ready` already rose counts as emitted.

## Timing
- **Read.** Request accepted in cycle t (R_IDLE):
  - `rd_ack` and `rd_data` at t+1.
  - `in_setready` high for t+1 … t+PULSE_LEN.
  - Low at t+PULSE_LEN+1.
  - R_IDLE again at t+PULSE_LEN+2, so the earliest next acceptance is 4 cycles after the previous one with defaults.
- **Write.** Push in cycle t into an empty FIFO with the write FSM idle:
  - Count becomes 1 at t+1 and W_IDLE loads `out_byte`.
  - W_SETUP at t+2.
  - `out_ready` high at t+2+SETUP … t+1+SETUP+PULSE_LEN.
  - W_HOLD with the pop at t+2+SETUP+PULSE_LEN.
  - With defaults: `out_ready` high at t+3 and t+4, pop at the end of t+5.
- **Throughput.** Back-to-back bytes take SETUP+PULSE_LEN+2 cycles each (5 with defaults).
- **`busy`.** Registered; it reflects the state and count of the previous edge.

## Structure
- Shared package `bf_io_pkg` holds:
  - `byte_t` (8-bit logic);
  - the enums `rd_state_t` {R_IDLE, R_PULSE, R_RECOVER} and `wr_state_t` {W_IDLE, W_SETUP, W_STROBE, W_HOLD};
  - the default parameter constants.
- One sub-module, `bf_io_fifo`: a parameterized synchronous FIFO (push/pop/full/empty/head) instantiated for the write path. The FSMs and strobe counters live in `bf_io_ctrl`.

## Test plan
- **Two reads.** Input queue head 0x48 then 0x69; `rd_req` at t → `rd_ack` with `rd_data` = 0x48 at t+1, and `in_setready` high at t+1 and t+2. A second read returns 0x69, with exactly two `in_setready` rising edges in total.
- **Single write.** Push 0x41 at t → `out_byte` = 0x41 from t+2 through t+5, `out_ready` high at t+3 and t+4 only, `busy` = 0 by t+7.
- **Write burst.** Push 0x10 … 0x15 on consecutive cycles from t:
  - `wr_ready` is low from t+4 until the first pop;
  - all six bytes are accepted eventually;
  - the output device logs 0x10 … 0x15 in order, with `out_ready` rising edges 5 cycles apart.
- **Concurrent traffic.** A read and a write issued in the same cycle → both complete with the same latency as when issued alone, and strobes are independent.
- **Reset mid-strobe.** `rst` during W_STROBE with 3 entries queued → `out_ready` and `out_byte` are 0 on the next edge, no further strobes appear, and `wr_ready` = 1 the cycle after `rst` falls.
